// File: rtl/key_demux_buf.sv
// Keyed demultiplexer: routes one {key, data} stream into per-key
// 1-entry holding registers, with optional default channel and miss counter.
module key_demux_buf #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 3,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_LEN-1:0]         in_key,
    input  logic [DATA_LEN-1:0]        in_data,
    input  logic [NR_KEY*KEY_LEN-1:0]  key_lut,
    output logic [NR_KEY-1:0]          out_valid,
    input  logic [NR_KEY-1:0]          out_ready,
    output logic [NR_KEY*DATA_LEN-1:0] out_data,
    output logic                       dflt_valid,
    input  logic                       dflt_ready,
    output logic [DATA_LEN-1:0]        dflt_data,
    output logic                       miss_pulse,
    output logic [7:0]                 miss_cnt
);

    logic [NR_KEY-1:0] hit;
    logic [NR_KEY-1:0] sel;
    logic [NR_KEY-1:0] slot_free;
    logic              any_hit;
    logic              tgt_free;
    logic              accept;
    logic              dflt_load;
    logic              drop;

    // Lowest matching index wins so a beat lands in exactly one channel.
    always_comb begin
        hit     = '0;
        sel     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            hit[i] = (in_key == key_lut[KEY_LEN*i +: KEY_LEN]);
            if (hit[i] && !any_hit) begin
                sel[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

    assign slot_free = ~out_valid | out_ready;

    always_comb begin
        if (any_hit) begin
            tgt_free = |(sel & slot_free);
        end else if (HAS_DEFAULT != 0) begin
            tgt_free = !dflt_valid || dflt_ready;
        end else begin
            tgt_free = 1'b1;
        end
    end

    assign in_ready  = !rst && tgt_free;
    assign accept    = in_valid && in_ready;
    assign dflt_load = accept && !any_hit && (HAS_DEFAULT != 0);
    assign drop      = accept && !any_hit && (HAS_DEFAULT == 0);

    // A refill on the draining edge wins over the drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (accept && sel[i]) begin
                    out_valid[i]                       <= 1'b1;
                    out_data[DATA_LEN*i +: DATA_LEN]   <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dflt_valid <= 1'b0;
            dflt_data  <= '0;
        end else if (dflt_load) begin
            dflt_valid <= 1'b1;
            dflt_data  <= in_data;
        end else if (dflt_ready) begin
            dflt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_pulse <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            miss_pulse <= drop;
            if (drop && miss_cnt != 8'hFF) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_demux_buf.sv
// Bench for key_demux_buf: directed table, corner sequences and a
// randomized run against a slot-occupancy model, for both default modes.
module tb_key_demux_buf;

    localparam int NK = 4;
    localparam int KL = 3;
    localparam int DL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid;
    logic [KL-1:0]    in_key;
    logic [DL-1:0]    in_data;
    logic [NK*KL-1:0] key_lut;
    logic [NK-1:0]    out_ready;
    logic             dflt_ready;

    logic             in_ready   [2];
    logic [NK-1:0]    out_valid  [2];
    logic [NK*DL-1:0] out_data   [2];
    logic             dflt_valid [2];
    logic [DL-1:0]    dflt_data  [2];
    logic             miss_pulse [2];
    logic [7:0]       miss_cnt   [2];

    key_demux_buf #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_key(in_key), .in_data(in_data), .key_lut(key_lut),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .dflt_valid(dflt_valid[0]), .dflt_ready(dflt_ready), .dflt_data(dflt_data[0]),
        .miss_pulse(miss_pulse[0]), .miss_cnt(miss_cnt[0])
    );

    key_demux_buf #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_key(in_key), .in_data(in_data), .key_lut(key_lut),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .dflt_valid(dflt_valid[1]), .dflt_ready(dflt_ready), .dflt_data(dflt_data[1]),
        .miss_pulse(miss_pulse[1]), .miss_cnt(miss_cnt[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [NK*KL-1:0] LUT_STD = {3'd7, 3'd5, 3'd2, 3'd0};

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready0", {31'd0, in_ready[0]}, 0);
        chk("rst_in_ready1", {31'd0, in_ready[1]}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [2:0] k, input logic [7:0] d,
                         input logic [3:0] r, input logic dr);
        in_valid   = v;
        in_key     = k;
        in_data    = d;
        out_ready  = r;
        dflt_ready = dr;
    endtask

    // Model: each slot is either full with a datum or empty; index 4 is default.
    typedef struct {
        bit         full [5];
        logic [7:0] dat  [5];
        bit         pulse;
        int         cnt;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mclear();
        mdl_t s;
        for (int i = 0; i < 5; i++) begin
            s.full[i] = 1'b0;
            s.dat[i]  = 8'h00;
        end
        s.pulse = 1'b0;
        s.cnt   = 0;
        return s;
    endfunction

    function automatic int target(input logic [2:0] k, input logic [11:0] lut);
        for (int i = 0; i < 4; i++)
            if (lut[i*3 +: 3] == k) return i;
        return -1;
    endfunction

    function automatic bit mfree(input mdl_t s, input int t, input bit hd,
                                 input logic [4:0] rdy);
        if (t >= 0) return !s.full[t] || rdy[t];
        if (hd) return !s.full[4] || rdy[4];
        return 1'b1;
    endfunction

    function automatic mdl_t mnext(input mdl_t s, input int t, input bit hd,
                                   input bit acc, input logic [4:0] rdy,
                                   input logic [7:0] d);
        mdl_t n = s;
        for (int i = 0; i < 5; i++)
            if (s.full[i] && rdy[i]) n.full[i] = 1'b0;
        n.pulse = 1'b0;
        if (acc) begin
            if (t >= 0) begin
                n.full[t] = 1'b1;
                n.dat[t]  = d;
            end else if (hd) begin
                n.full[4] = 1'b1;
                n.dat[4]  = d;
            end else begin
                n.pulse = 1'b1;
                n.cnt   = (s.cnt < 255) ? s.cnt + 1 : 255;
            end
        end
        return n;
    endfunction

    task automatic cmp_model(input int d);
        logic [NK-1:0]    ev;
        logic [NK*DL-1:0] ed;
        for (int i = 0; i < NK; i++) begin
            ev[i]          = m[d].full[i];
            ed[i*DL +: DL] = m[d].dat[i];
        end
        chk($sformatf("rnd%0d_out_valid", d), {28'd0, out_valid[d]}, {28'd0, ev});
        chk($sformatf("rnd%0d_out_data", d), out_data[d], ed);
        chk($sformatf("rnd%0d_dflt_valid", d), {31'd0, dflt_valid[d]}, {31'd0, m[d].full[4]});
        chk($sformatf("rnd%0d_dflt_data", d), {24'd0, dflt_data[d]}, {24'd0, m[d].dat[4]});
        chk($sformatf("rnd%0d_miss_pulse", d), {31'd0, miss_pulse[d]}, {31'd0, m[d].pulse});
        chk($sformatf("rnd%0d_miss_cnt", d), {24'd0, miss_cnt[d]}, m[d].cnt);
    endtask

    typedef struct {
        logic       v;
        logic [2:0] key;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       e_rdy;
        logic [3:0] e_val;
        logic       e_pulse;
        logic [7:0] e_cnt;
        logic [7:0] e_d2;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 3'd5, 8'hA5, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'd0, 8'hA5};
        tbl[1] = '{1'b1, 3'd5, 8'hB6, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'd0, 8'hA5};
        tbl[2] = '{1'b1, 3'd5, 8'hB6, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'd0, 8'hB6};
        tbl[3] = '{1'b1, 3'd0, 8'h11, 4'b1111, 1'b1, 4'b0001, 1'b0, 8'd0, 8'hB6};
        tbl[4] = '{1'b1, 3'd2, 8'h22, 4'b1111, 1'b1, 4'b0010, 1'b0, 8'd0, 8'hB6};
        tbl[5] = '{1'b1, 3'd7, 8'h33, 4'b1111, 1'b1, 4'b1000, 1'b0, 8'd0, 8'hB6};
        tbl[6] = '{1'b1, 3'd3, 8'h3C, 4'b1111, 1'b1, 4'b0000, 1'b1, 8'd1, 8'hB6};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'd1, 8'hB6};

        key_lut = LUT_STD;
        drive(1'b0, 3'd0, 8'h00, 4'b0000, 1'b0);
        do_reset();
        chk("reset_out_valid", {28'd0, out_valid[0]}, 0);
        chk("reset_out_data", out_data[0], 0);
        chk("reset_dflt_valid", {31'd0, dflt_valid[1]}, 0);
        chk("reset_miss_cnt", {24'd0, miss_cnt[0]}, 0);
        chk("reset_miss_pulse", {31'd0, miss_pulse[0]}, 0);

        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].v, tbl[r].key, tbl[r].d, tbl[r].rdy, 1'b1);
            @(negedge clk);
            if (tbl[r].v)
                chk($sformatf("tbl%0d_in_ready", r), {31'd0, in_ready[0]}, {31'd0, tbl[r].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", r), {28'd0, out_valid[0]}, {28'd0, tbl[r].e_val});
            chk($sformatf("tbl%0d_miss_pulse", r), {31'd0, miss_pulse[0]}, {31'd0, tbl[r].e_pulse});
            chk($sformatf("tbl%0d_miss_cnt", r), {24'd0, miss_cnt[0]}, {24'd0, tbl[r].e_cnt});
            chk($sformatf("tbl%0d_ch2_data", r), {24'd0, out_data[0][23:16]}, {24'd0, tbl[r].e_d2});
        end

        // Saturating miss counter.
        drive(1'b1, 3'd3, 8'h3C, 4'b1111, 1'b1);
        repeat (300) @(posedge clk);
        #1;
        chk("sat_miss_pulse", {31'd0, miss_pulse[0]}, 1);
        chk("sat_miss_cnt", {24'd0, miss_cnt[0]}, 255);
        chk("sat_no_default_valid", {31'd0, dflt_valid[0]}, 0);
        drive(1'b0, 3'd0, 8'h00, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_hold_cnt", {24'd0, miss_cnt[0]}, 255);
        chk("sat_pulse_off", {31'd0, miss_pulse[0]}, 0);

        // Default channel back-pressure.
        do_reset();
        drive(1'b1, 3'd3, 8'h3C, 4'b0000, 1'b0);
        @(negedge clk);
        chk("dflt_in_ready_first", {31'd0, in_ready[1]}, 1);
        @(posedge clk);
        #1;
        chk("dflt_valid_set", {31'd0, dflt_valid[1]}, 1);
        chk("dflt_data_3c", {24'd0, dflt_data[1]}, 8'h3C);
        chk("dflt_miss_cnt", {24'd0, miss_cnt[1]}, 0);
        chk("dflt_out_valid", {28'd0, out_valid[1]}, 0);
        drive(1'b1, 3'd3, 8'h4D, 4'b0000, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("dflt_stall_ready", {31'd0, in_ready[1]}, 0);
            @(posedge clk);
            #1;
            chk("dflt_stall_data", {24'd0, dflt_data[1]}, 8'h3C);
        end
        dflt_ready = 1'b1;
        @(negedge clk);
        chk("dflt_release_ready", {31'd0, in_ready[1]}, 1);
        @(posedge clk);
        #1;
        chk("dflt_refill_valid", {31'd0, dflt_valid[1]}, 1);
        chk("dflt_refill_data", {24'd0, dflt_data[1]}, 8'h4D);

        // Duplicate keys: lowest index only.
        do_reset();
        key_lut = {3'd1, 3'd1, 3'd1, 3'd1};
        drive(1'b1, 3'd1, 8'h77, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk("dup_out_valid0", {28'd0, out_valid[0]}, 4'b0001);
        chk("dup_out_valid1", {28'd0, out_valid[1]}, 4'b0001);
        chk("dup_ch0_data", {24'd0, out_data[0][7:0]}, 8'h77);

        // Reset while all channels are full.
        do_reset();
        key_lut = LUT_STD;
        drive(1'b1, 3'd3, 8'h01, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [11:0] lut_v;
            lut_v = LUT_STD;
            drive(1'b1, lut_v[k*3 +: 3], 8'h10 + 8'(k), 4'b0000, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("full_out_valid", {28'd0, out_valid[0]}, 4'b1111);
        chk("full_miss_cnt", {24'd0, miss_cnt[0]}, 1);
        do_reset();
        chk("rstfull_out_valid0", {28'd0, out_valid[0]}, 0);
        chk("rstfull_out_valid1", {28'd0, out_valid[1]}, 0);
        chk("rstfull_dflt_valid", {31'd0, dflt_valid[1]}, 0);
        chk("rstfull_miss_cnt", {24'd0, miss_cnt[0]}, 0);

        // Randomized run against the model, both default modes.
        m[0] = mclear();
        m[1] = mclear();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rdy;
            bit         er [2];
            int         t;
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) key_lut = NK*KL'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom));
            rdy = {dflt_ready, out_ready};
            t   = target(in_key, key_lut);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cmp_model(d);
                er[d] = !rst && mfree(m[d], t, bit'(d), rdy);
                chk($sformatf("rnd%0d_in_ready", d), {31'd0, in_ready[d]}, {31'd0, er[d]});
            end
            for (int d = 0; d < 2; d++) begin
                if (rst) m[d] = mclear();
                else     m[d] = mnext(m[d], t, bit'(d), in_valid && er[d], rdy, in_data);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
